// File: rtl/alu_issue.sv
// Operand-issue and writeback stage around a combinational ALU: bypassed register
// reads feed a registered E stage, whose ALU result is captured in W and retired.
module alu_issue #(
    parameter int N    = 32,
    parameter int NREG = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(NREG)-1:0] in_rs,
    input  logic [$clog2(NREG)-1:0] in_rt,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic [N-1:0]            in_imm,
    input  logic                    in_bsel,
    input  logic [4:0]              in_alufn,
    input  logic                    in_wr,
    output logic [N-1:0]            A,
    output logic [N-1:0]            B,
    output logic [4:0]              ALUfn,
    input  logic [N-1:0]            R,
    input  logic                    Z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_result,
    output logic                    out_zero,
    output logic [$clog2(NREG)-1:0] out_rd
);
    localparam int IW = $clog2(NREG);

    logic          e_valid;
    logic          e_wr;
    logic [IW-1:0] e_rd;
    logic          w_wr;
    logic          w_free;
    logic          e_free;
    logic          issue;
    logic          retire;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [N-1:0]  regs [NREG];
    logic [NREG-1:0] wr_en;

    assign w_free   = ~out_valid | out_ready;
    assign e_free   = ~e_valid | w_free;
    assign in_ready = e_free;
    assign issue    = in_valid & in_ready;
    assign retire   = out_valid & out_ready;

    // Youngest producer wins: E (live ALU result) before W before the file.
    always_comb begin
        op_a = regs[in_rs];
        if (in_rs == '0)
            op_a = '0;
        else if (e_valid && e_wr && e_rd == in_rs)
            op_a = R;
        else if (out_valid && w_wr && out_rd == in_rs)
            op_a = out_result;
    end

    always_comb begin
        op_b = regs[in_rt];
        if (in_bsel)
            op_b = in_imm;
        else if (in_rt == '0)
            op_b = '0;
        else if (e_valid && e_wr && e_rd == in_rt)
            op_b = R;
        else if (out_valid && w_wr && out_rd == in_rt)
            op_b = out_result;
    end

    // Entry 0 never gets a write enable, so it stays at its reset value of zero.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        assign wr_en[gi] = retire & w_wr & (out_rd == IW'(gi)) & (gi != 0);

        always_ff @(posedge clock) begin
            if (reset)
                regs[gi] <= '0;
            else if (wr_en[gi])
                regs[gi] <= out_result;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_valid <= 1'b0;
            e_wr    <= 1'b0;
            e_rd    <= '0;
            A       <= '0;
            B       <= '0;
            ALUfn   <= '0;
        end else if (issue) begin
            e_valid <= 1'b1;
            e_wr    <= in_wr;
            e_rd    <= in_rd;
            A       <= op_a;
            B       <= op_b;
            ALUfn   <= in_alufn;
        end else if (e_free) begin
            e_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_rd     <= '0;
            w_wr       <= 1'b0;
        end else if (e_valid && w_free) begin
            out_valid  <= 1'b1;
            out_result <= R;
            out_zero   <= Z;
            out_rd     <= e_rd;
            w_wr       <= e_wr;
        end else if (w_free) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU; expected retirements are
// queued at issue time and compared by an independent monitor.
module tb_alu_issue;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [31:0] in_imm;
    logic        in_bsel;
    logic [4:0]  in_alufn;
    logic        in_wr;
    logic [31:0] A, B;
    logic [4:0]  ALUfn;
    logic [31:0] R;
    logic        Z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  rd;
    } exp_t;
    exp_t sb[$];

    localparam logic [4:0] ADD = 5'b00001;
    localparam logic [4:0] SUB = 5'b10001;

    alu_issue #(.N(32), .NREG(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_bsel(in_bsel), .in_alufn(in_alufn), .in_wr(in_wr),
        .A(A), .B(B), .ALUfn(ALUfn), .R(R), .Z(Z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: {subtract, bool1, bool0, shft, math}
    always_comb begin
        R = '0;
        if (ALUfn[0])
            R = ALUfn[4] ? A - B : A + B;
        else if (ALUfn[1])
            R = A << B[4:0];
        else begin
            case (ALUfn[3:2])
                2'b00:   R = A & B;
                2'b01:   R = A | B;
                2'b10:   R = A ^ B;
                default: R = A;
            endcase
        end
    end
    assign Z = (R == '0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got rd=%0d result=%0h expected none", out_rd, out_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("retire rd=%0d result=%0h zero=%0b", out_rd, out_result, out_zero);
                chk("ret_result", out_result, e.res);
                chk("ret_zero", {31'b0, out_zero}, {31'b0, e.zero});
                chk("ret_rd", {27'b0, out_rd}, {27'b0, e.rd});
            end
        end
    end

    task automatic set_instr(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [31:0] imm, input logic bsel, input logic [4:0] fn,
                             input logic wr, input logic [31:0] eres, input logic ezero);
        in_valid = 1'b1;
        in_rd    = rd;
        in_rs    = rs;
        in_rt    = rt;
        in_imm   = imm;
        in_bsel  = bsel;
        in_alufn = fn;
        in_wr    = wr;
        sb.push_back('{res: eres, zero: ezero, rd: rd});
    endtask

    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got in_ready=0 for 50 cycles expected 1", name);
        end
        @(posedge clock);
        #1;
        $display("issue %s A=%0h B=%0h ALUfn=%b", name, A, B, ALUfn);
    endtask

    task automatic issue(input string name, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] imm, input logic bsel,
                         input logic [4:0] fn, input logic wr, input logic [31:0] eres,
                         input logic ezero);
        set_instr(rd, rs, rt, imm, bsel, fn, wr, eres, ezero);
        wait_accept(name);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        in_bsel = 1'b0; in_alufn = '0; in_wr = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);

        // Basic issue and latency
        issue("add_imm", 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, ADD, 1'b1, 32'd5, 1'b0);
        chk("t1_A", A, 0);
        chk("t1_B", B, 5);
        chk("t1_ALUfn", {27'b0, ALUfn}, {27'b0, ADD});
        idle(1);
        chk("t1_out_valid", {31'b0, out_valid}, 1);
        chk("t1_out_result", out_result, 5);
        chk("t1_out_rd", {27'b0, out_rd}, 1);

        // E bypass chain
        issue("r1", 5'd1, 5'd0, 5'd0, 32'd7, 1'b1, ADD, 1'b1, 32'd7, 1'b0);
        issue("r2", 5'd2, 5'd1, 5'd1, 32'd0, 1'b0, ADD, 1'b1, 32'd14, 1'b0);
        chk("ebyp_A", A, 7);
        chk("ebyp_B", B, 7);
        issue("r3", 5'd3, 5'd2, 5'd2, 32'd0, 1'b0, SUB, 1'b1, 32'd0, 1'b1);
        chk("ebyp2_A", A, 14);
        chk("ebyp2_B", B, 14);

        // W bypass, then file read
        issue("r4", 5'd4, 5'd0, 5'd0, 32'd3, 1'b1, ADD, 1'b1, 32'd3, 1'b0);
        idle(1);
        issue("r5", 5'd5, 5'd4, 5'd0, 32'd1, 1'b1, ADD, 1'b1, 32'd4, 1'b0);
        chk("wbyp_A", A, 3);
        chk("wbyp_B", B, 1);
        idle(3);
        issue("r6", 5'd6, 5'd5, 5'd0, 32'd0, 1'b1, ADD, 1'b1, 32'd4, 1'b0);
        chk("file_A", A, 4);

        // Backpressure: two accepted, third stalls
        drain();
        out_ready = 1'b0;
        issue("r7", 5'd7, 5'd0, 5'd0, 32'd10, 1'b1, ADD, 1'b1, 32'd10, 1'b0);
        issue("r8", 5'd8, 5'd0, 5'd0, 32'd20, 1'b1, ADD, 1'b1, 32'd20, 1'b0);
        set_instr(5'd9, 5'd0, 5'd0, 32'd30, 1'b1, ADD, 1'b1, 32'd30, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            chk("bp_A", A, 0);
            chk("bp_B", B, 20);
            chk("bp_out_valid", {31'b0, out_valid}, 1);
            chk("bp_out_result", out_result, 10);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        wait_accept("r9");
        chk("bp_r9_B", B, 30);
        drain();

        // Writes to r0 are discarded and never bypassed
        issue("r0w", 5'd0, 5'd0, 5'd0, 32'd9, 1'b1, ADD, 1'b1, 32'd9, 1'b0);
        issue("r0r", 5'd10, 5'd0, 5'd0, 32'd1, 1'b1, ADD, 1'b1, 32'd1, 1'b0);
        chk("r0_A", A, 0);
        idle(4);
        issue("r0f", 5'd11, 5'd0, 5'd0, 32'd0, 1'b0, ADD, 1'b1, 32'd0, 1'b1);
        chk("r0f_A", A, 0);
        chk("r0f_B", B, 0);
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        issue("r12", 5'd12, 5'd0, 5'd0, 32'h55, 1'b1, ADD, 1'b1, 32'h55, 1'b0);
        issue("r13", 5'd13, 5'd0, 5'd0, 32'h66, 1'b1, ADD, 1'b1, 32'h66, 1'b0);
        in_valid = 1'b0;
        sb.delete();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        chk("mrst_out_valid", {31'b0, out_valid}, 0);
        chk("mrst_A", A, 0);
        chk("mrst_B", B, 0);
        chk("mrst_in_ready", {31'b0, in_ready}, 1);
        issue("post_rst", 5'd14, 5'd5, 5'd7, 32'd0, 1'b0, ADD, 1'b1, 32'd0, 1'b1);
        chk("mrst_r5", A, 0);
        chk("mrst_r7", B, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue and writeback stage wrapped around the datapath ALU. Accepts decoded instructions on a valid/ready handshake, reads operands from an internal N-bit register file with full bypassing, and presents registered `A`, `B`, `ALUfn` to the combinational ALU. It then captures the ALU result `R` and zero flag into a writeback register and retires it to the register file. This forms a two-stage execute/writeback pipeline with backpressure from downstream.

## Interface
Parameters:
- `N`, 32, datapath width (A, B, R, immediate, register width)
- `NREG`, 32, register count; index width `$clog2(NREG)`; register 0 hardwired to zero

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  decoded instruction offered
- `in_ready`  out  1  instruction accepted when `in_valid & in_ready`
- `in_rs`, `in_rt`  in  `$clog2(NREG)`  source register indices
- `in_rd`  in  `$clog2(NREG)`  destination index
- `in_imm`  in  N  immediate, already sign/zero-extended upstream
- `in_bsel`  in  1  1: B = `in_imm`; 0: B = reg[`in_rt`]
- `in_alufn`  in  5  ALU function {subtract, bool1, bool0, shft, math}
- `in_wr`  in  1  instruction writes `in_rd`
- `A`, `B`  out  N  registered ALU operands (E stage)
- `ALUfn`  out  5  registered ALU function (E stage)
- `R`  in  N  ALU result, combinational from `A`, `B`, `ALUfn`
- `Z`  in  1  ALU FlagZ
- `out_valid`  out  1  W stage holds a result
- `out_ready`  in  1  downstream accepts result
- `out_result`  out  N  retired result
- `out_zero`  out  1  retired zero flag
- `out_rd`  out  `$clog2(NREG)`  retired destination index

## Operation
- Two stages. **E** holds `A`, `B`, `ALUfn`, e_rd, e_wr, e_valid. **W** holds `out_result`, `out_zero`, `out_rd`, w_wr, `out_valid`.
- Advance conditions: w_free = ~`out_valid` | `out_ready`; e_free = ~e_valid | w_free; `in_ready` = e_free (combinational).
- Issue (`in_valid & in_ready`): E loads resolved operands, `in_alufn`, `in_rd`, `in_wr`; e_valid ← 1. Otherwise, if e_free, e_valid ← 0. If not e_free, E holds.
- E→W when e_valid & w_free: W loads `R`, `Z`, e_rd, e_wr; `out_valid` ← 1. Otherwise, if w_free, `out_valid` ← 0.
- Retire (`out_valid & out_ready`): if w_wr and `out_rd` ≠ 0, reg[`out_rd`] ← `out_result`.
- Operand resolution for each of rs and (when `in_bsel`=0) rt, in priority order:
  - index 0 → 0;
  - e_valid & e_wr & e_rd == idx → `R`;
  - `out_valid` & w_wr & `out_rd` == idx → `out_result`;
  - else reg[idx].
- `in_bsel`=1: B = `in_imm`; rt is ignored.
- Register file: NREG×N, asynchronous read, one synchronous write port; reg 0 never written, reads 0.
- No stalls for dependencies: every read-after-write is covered by bypass.

## Timing
- Reset (synchronous): e_valid, `out_valid`, `A`, `B`, `ALUfn`, `out_result`, `out_zero`, `out_rd`, and all registers cleared to 0. `in_ready`=1 in the first cycle after reset.
- Latency: accepted at edge t → `A`/`B`/`ALUfn` valid after t; `out_valid`=1 with result after t+1. Throughput 1/cycle while `out_ready`=1.
- Back-to-back dependent instructions: bypass from E. Dependency two apart: bypass from W. Three or more apart: read from the file.
- Same-cycle retire of reg k and issue reading k: W bypass supplies the value, so no stale read.
- Backpressure: with `out_ready`=0 and both stages full, `in_ready`=0 and E, W, and `A`/`B`/`ALUfn` hold stable. A waiting E entry's `R` is recomputed each cycle from held operands and stays stable.
- Reset mid-operation: in-flight E/W entries discarded, no retire in the reset cycle.
- Width rule: all datapaths are N bits, no carry-out kept. Register indices compare on full index width.

## Test plan
- After reset, issue ADD (`00001`) rd=1, rs=0, imm=5, bsel=1 → next cycle A=0, B=5, ALUfn=00001; following cycle `out_valid`=1, `out_result`=5, `out_rd`=1.
- r1←r0+7, then immediately r2←r1+r1 (bsel=0) → second issue shows A=B=7 (E bypass); r2 result 14. A third instruction r3←r2 SUB (`10001`) r2 → `out_result`=0, `out_zero`=1.
- r4←r0+3, one bubble, r5←r4+imm 1 → A=3 via W bypass, `out_result`=4. After 3 more cycles, r5 read returns 4 from the file.
- Hold `out_ready`=0, offer 3 back-to-back instructions → exactly 2 accepted, `in_ready`=0, outputs stable. Release → results retire in order, no loss or duplication, third accepted.
- Write rd=0, wr=1, result 9, then read rs=0 in the next instruction → A=0 (no bypass for r0), and the file r0 remains 0.
- Assert `reset` with E and W valid → next cycle `out_valid`=0, A=B=0, and a read of any previously written register returns 0.
